// File: rtl/scroll_addr_gen_if.sv
// Pixel-coordinate stream between the VGA timing controller (master) and the
// scroll address generator (slave): coordinates in, image address out.
interface scroll_addr_gen_if #(
    parameter int CNT_W  = 10,
    parameter int ADDR_W = 17
);
    logic              in_valid;
    logic [CNT_W-1:0]  h_cnt;
    logic [CNT_W-1:0]  v_cnt;
    logic [ADDR_W-1:0] pixel_addr;
    logic              pixel_valid;

    modport master (
        output in_valid, h_cnt, v_cnt,
        input  pixel_addr, pixel_valid
    );

    modport slave (
        input  in_valid, h_cnt, v_cnt,
        output pixel_addr, pixel_valid
    );
endinterface

// File: rtl/scroll_addr_gen.sv
// Frame-buffer address generator with tear-free wrap-around scroll, latency 2.
// Optional macro SCROLL_Y_EN adds per-frame vertical auto-scroll.
module scroll_addr_gen #(
    parameter int  WIDTH       = 320,
    parameter int  HEIGHT      = 240,
    parameter int  SCALE_SHIFT = 1,
    parameter int  CNT_W       = 10,
    parameter int  STEP_W      = 4,
    localparam int X_W         = $clog2(WIDTH),
    localparam int Y_W         = $clog2(HEIGHT),
    localparam int ADDR_W      = $clog2(WIDTH * HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_tick,
    input  logic              scroll_en,
    input  logic [STEP_W-1:0] step_x,
    input  logic [STEP_W-1:0] step_y,
    input  logic              load,
    input  logic [X_W-1:0]    load_x,
    input  logic [Y_W-1:0]    load_y,
    output logic [X_W-1:0]    off_x,
    output logic [Y_W-1:0]    off_y,
    scroll_addr_gen_if.slave  pix
);

    localparam logic [X_W:0] W_EXT = (X_W + 1)'(WIDTH);
    localparam logic [Y_W:0] H_EXT = (Y_W + 1)'(HEIGHT);

    // Every operand is below 2*range, so one compare-subtract replaces a modulo.
    function automatic logic [X_W-1:0] wrap_x(input logic [X_W:0] v);
        return (v >= W_EXT) ? X_W'(v - W_EXT) : X_W'(v);
    endfunction

    function automatic logic [Y_W-1:0] wrap_y(input logic [Y_W:0] v);
        return (v >= H_EXT) ? Y_W'(v - H_EXT) : Y_W'(v);
    endfunction

    logic [X_W-1:0] ld_x_mod;
    logic [Y_W-1:0] ld_y_mod;
    logic [X_W-1:0] step_x_next;
    logic [Y_W-1:0] step_y_next;
    logic [X_W-1:0] shadow_x;
    logic [Y_W-1:0] shadow_y;
    logic           pending;

    assign ld_x_mod    = wrap_x({1'b0, load_x});
    assign ld_y_mod    = wrap_y({1'b0, load_y});
    assign step_x_next = wrap_x({1'b0, off_x} + (X_W + 1)'(step_x));

`ifdef SCROLL_Y_EN
    assign step_y_next = wrap_y({1'b0, off_y} + (Y_W + 1)'(step_y));
`else
    logic unused_step_y;
    assign unused_step_y = ^step_y;
    assign step_y_next   = off_y;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            off_x    <= '0;
            off_y    <= '0;
            shadow_x <= '0;
            shadow_y <= '0;
            pending  <= 1'b0;
        end else begin
            if (load) begin
                shadow_x <= ld_x_mod;
                shadow_y <= ld_y_mod;
            end
            if (frame_tick) begin
                // A load coinciding with the tick takes effect immediately.
                if (load) begin
                    off_x   <= ld_x_mod;
                    off_y   <= ld_y_mod;
                    pending <= 1'b0;
                end else if (pending) begin
                    off_x   <= shadow_x;
                    off_y   <= shadow_y;
                    pending <= 1'b0;
                end else if (scroll_en) begin
                    off_x <= step_x_next;
                    off_y <= step_y_next;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    logic [CNT_W-1:0] h_addr;
    logic [CNT_W-1:0] v_addr;
    logic             in_range;
    logic [X_W-1:0]   pic_x_d;
    logic [Y_W-1:0]   pic_y_d;

    assign h_addr   = pix.h_cnt >> SCALE_SHIFT;
    assign v_addr   = pix.v_cnt >> SCALE_SHIFT;
    assign in_range = (32'(h_addr) < WIDTH) && (32'(v_addr) < HEIGHT);
    assign pic_x_d  = wrap_x({1'b0, h_addr[X_W-1:0]} + {1'b0, off_x});
    assign pic_y_d  = wrap_y({1'b0, v_addr[Y_W-1:0]} + {1'b0, off_y});

    logic [X_W-1:0] pic_x_q;
    logic [Y_W-1:0] pic_y_q;
    logic           v1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pic_x_q         <= '0;
            pic_y_q         <= '0;
            v1              <= 1'b0;
            pix.pixel_addr  <= '0;
            pix.pixel_valid <= 1'b0;
        end else begin
            pic_x_q         <= pic_x_d;
            pic_y_q         <= pic_y_d;
            v1              <= pix.in_valid && in_range;
            pix.pixel_addr  <= v1 ? ADDR_W'(pic_y_q) * ADDR_W'(WIDTH) + ADDR_W'(pic_x_q)
                                  : '0;
            pix.pixel_valid <= v1;
        end
    end

endmodule

// File: tb/tb_scroll_addr_gen.sv
// Directed self-checking bench for scroll_addr_gen (320x240, SCALE_SHIFT=1).
module tb_scroll_addr_gen;

    localparam int WIDTH  = 320;
    localparam int HEIGHT = 240;
    localparam int CNT_W  = 10;
    localparam int STEP_W = 4;
    localparam int X_W    = 9;
    localparam int Y_W    = 8;
    localparam int ADDR_W = 17;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_tick;
    logic              scroll_en;
    logic [STEP_W-1:0] step_x;
    logic [STEP_W-1:0] step_y;
    logic              load;
    logic [X_W-1:0]    load_x;
    logic [Y_W-1:0]    load_y;
    logic [X_W-1:0]    off_x;
    logic [Y_W-1:0]    off_y;

    scroll_addr_gen_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) pif ();

    scroll_addr_gen #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .SCALE_SHIFT(1), .CNT_W(CNT_W), .STEP_W(STEP_W)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .scroll_en(scroll_en),
        .step_x(step_x), .step_y(step_y), .load(load), .load_x(load_x),
        .load_y(load_y), .off_x(off_x), .off_y(off_y), .pix(pif.slave)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    typedef struct {
        logic             in_valid;
        logic [CNT_W-1:0] h_cnt;
        logic [CNT_W-1:0] v_cnt;
        logic             exp_valid;
        int               exp_addr;
    } vec_t;

    vec_t vecs[9];

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_load(input int x, input int y);
        load = 1'b1; load_x = X_W'(x); load_y = Y_W'(y);
        cyc();
        load = 1'b0;
    endtask

    task automatic do_frame();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic map_check(input string name, input int h, input int v,
                             input int exp_addr);
        pif.in_valid = 1'b1; pif.h_cnt = CNT_W'(h); pif.v_cnt = CNT_W'(v);
        cyc();
        pif.in_valid = 1'b0;
        cyc();
        check({name, " valid"}, int'(pif.pixel_valid), 1);
        check({name, " addr"}, int'(pif.pixel_addr), exp_addr);
    endtask

    initial begin
        // Offsets zero: addr = (v>>1)*320 + (h>>1) when in range, else 0.
        vecs[0] = '{1'b1,  10'd10,   10'd4, 1'b1,   645};
        vecs[1] = '{1'b1,   10'd0,   10'd0, 1'b1,     0};
        vecs[2] = '{1'b1, 10'd639, 10'd479, 1'b1, 76799};
        vecs[3] = '{1'b1, 10'd640,   10'd0, 1'b0,     0};
        vecs[4] = '{1'b1,   10'd0, 10'd480, 1'b0,     0};
        vecs[5] = '{1'b0,  10'd10,   10'd4, 1'b0,     0};
        vecs[6] = '{1'b1,  10'd11,   10'd5, 1'b1,   645};
        vecs[7] = '{1'b1, 10'd200, 10'd100, 1'b1, 16100};
        vecs[8] = '{1'b1, 10'd1023, 10'd1023, 1'b0,   0};

        rst = 1'b0; frame_tick = 1'b0; scroll_en = 1'b0; step_x = '0; step_y = '0;
        load = 1'b0; load_x = '0; load_y = '0;
        pif.in_valid = 1'b0; pif.h_cnt = '0; pif.v_cnt = '0;

        repeat (3) cyc();
        check("rst pixel_valid", int'(pif.pixel_valid), 0);
        check("rst pixel_addr", int'(pif.pixel_addr), 0);
        check("rst off_x", int'(off_x), 0);
        check("rst off_y", int'(off_y), 0);
        rst = 1'b1;
        repeat (3) cyc();
        check("idle pixel_valid", int'(pif.pixel_valid), 0);
        check("idle pixel_addr", int'(pif.pixel_addr), 0);

        // Back-to-back stream: the result for vector i appears two cycles later.
        for (int i = 0; i < 11; i++) begin
            if (i >= 2) begin
                check($sformatf("vec%0d valid", i - 2), int'(pif.pixel_valid),
                      int'(vecs[i-2].exp_valid));
                check($sformatf("vec%0d addr", i - 2), int'(pif.pixel_addr),
                      vecs[i-2].exp_addr);
            end
            if (i < 9) begin
                pif.in_valid = vecs[i].in_valid;
                pif.h_cnt    = vecs[i].h_cnt;
                pif.v_cnt    = vecs[i].v_cnt;
            end else begin
                pif.in_valid = 1'b0;
            end
            cyc();
        end

        // Reset with two entries in flight clears both immediately.
        pif.in_valid = 1'b1; pif.h_cnt = 10'd10; pif.v_cnt = 10'd4;
        cyc();
        pif.h_cnt = 10'd200; pif.v_cnt = 10'd100;
        @(posedge clk); #1;
        check("pre-rst valid", int'(pif.pixel_valid), 1);
        #2 rst = 1'b0;
        #1;
        check("async rst valid", int'(pif.pixel_valid), 0);
        check("async rst addr", int'(pif.pixel_addr), 0);
        cyc();
        rst = 1'b1; pif.in_valid = 1'b0;
        cyc();
        check("post-rst stage1 flushed", int'(pif.pixel_valid), 0);
        map_check("post-rst map", 10, 4, 645);

        // X wrap via load, then auto-scroll across the right edge.
        do_load(318, 0);
        check("shadow holds off_x", int'(off_x), 0);
        do_frame();
        check("load applied off_x", int'(off_x), 318);
        scroll_en = 1'b1; step_x = 4'd5;
        do_frame();
        check("x wrap off_x", int'(off_x), 3);
        map_check("x wrap map", 638, 0, 2);
        map_check("x offset map", 10, 4, 648);

        // Shadow: modulo on load, no tearing, load overrides the step.
        do_load(400, 0);
        repeat (3) cyc();
        check("mid-frame off_x", int'(off_x), 3);
        do_frame();
        check("shadow 400 mod 320", int'(off_x), 80);
        do_frame();
        check("step after shadow", int'(off_x), 85);
        load = 1'b1; load_x = 9'd7; load_y = '0; frame_tick = 1'b1;
        cyc();
        load = 1'b0; frame_tick = 1'b0;
        check("load+tick off_x", int'(off_x), 7);
        do_frame();
        check("no stale pending", int'(off_x), 12);

        // Y offset and y wrap.
        scroll_en = 1'b0; step_x = '0;
        do_load(0, 238);
        do_frame();
        check("load off_y", int'(off_y), 238);
        check("load off_x zero", int'(off_x), 0);
        scroll_en = 1'b1; step_y = 4'd3;
        do_frame();
`ifdef SCROLL_Y_EN
        check("y scroll off_y", int'(off_y), 1);
        map_check("y scroll map", 0, 4, 960);
`else
        check("y fixed off_y", int'(off_y), 238);
        map_check("y wrap map", 0, 4, 0);
`endif
        check("off_x step 0", int'(off_x), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/scroll_addr_gen.md
Name: scroll_addr_gen

Overview:
Pipelined, parametrised frame-buffer address generator for the VGA pixel path. It maps scaled screen coordinates (h_cnt, v_cnt) to a linear ROM/BRAM pixel address, applying a wrap-around scroll offset. The offset can be auto-advanced once per frame or loaded through a shadow register, so scroll changes never tear mid-frame. It sits between the VGA timing controller and the background image memory; the pixel mux consumes pixel_valid.

Parameters:
WIDTH, 320, image width in pixels (must be >= 2)
HEIGHT, 240, image height in pixels (must be >= 2)
SCALE_SHIFT, 1, screen-to-image downscale; h_addr = h_cnt >> SCALE_SHIFT, same for v
CNT_W, 10, width of h_cnt/v_cnt
STEP_W, 4, width of scroll step inputs; step values must be < WIDTH (and < HEIGHT for y)
Local: X_W = $clog2(WIDTH), Y_W = $clog2(HEIGHT), ADDR_W = $clog2(WIDTH*HEIGHT)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
frame_tick  in  1  one-cycle pulse at start of vertical blanking
scroll_en  in  1  enables auto-scroll on frame_tick
step_x  in  STEP_W  x advance per frame
step_y  in  STEP_W  y advance per frame (SCROLL_Y_EN only; ignored otherwise)
load  in  1  one-cycle strobe capturing load_x/load_y into shadow
load_x  in  X_W  new x offset
load_y  in  Y_W  new y offset
in_valid  in  1  h_cnt/v_cnt are in active video
h_cnt  in  CNT_W  horizontal pixel counter
v_cnt  in  CNT_W  vertical pixel counter
off_x  out  X_W  current x offset
off_y  out  Y_W  current y offset
pixel_addr  out  ADDR_W  image address
pixel_valid  out  1  pixel_addr is valid

Behaviour:
- Reset (rst low, async): off_x=0, off_y=0, shadow empty, pipeline valids 0, pixel_addr=0, pixel_valid=0.
- Load: on load, shadow_x = load_x mod WIDTH (single conditional subtract; load_x < 2*WIDTH always), likewise y; pending flag set. A later load before frame_tick overwrites the shadow.
- On frame_tick: if pending, off <= shadow and pending clears; no auto-scroll that frame. Else if scroll_en, off_x <= (off_x + step_x) wrapped mod WIDTH via compare-subtract. off_y changes only with SCROLL_Y_EN.
- load and frame_tick in the same cycle: the new load values are applied directly to off at that tick; pending stays clear.
- Offsets change only on frame_tick.
- Mapping: pic_x = (h_addr + off_x) mod WIDTH, pic_y = (v_addr + off_y) mod HEIGHT, pixel_addr = pic_y*WIDTH + pic_x. No % operator; each sum is < 2*range, so use one conditional subtract.
- Pipeline, latency 2:
  - Stage 1 registers pic_x, pic_y, and v1 = in_valid && h_addr < WIDTH && v_addr < HEIGHT.
  - Stage 2 registers pixel_addr and pixel_valid = v1.
- Out-of-range or invalid input yields pixel_valid=0 and pixel_addr=0 two cycles later.
- Fully pipelined; one new coordinate accepted every cycle, no stalls.
- Reset mid-frame clears in-flight pipeline entries immediately. The output is valid again 2 cycles after the first valid input following reset release.

Optional Feature:
SCROLL_Y_EN: when defined, frame_tick with scroll_en also advances off_y <= (off_y + step_y) mod HEIGHT. When undefined, step_y is unused and off_y changes only via load/reset; the y wrap adder is removed.

Test Plan:
- Reset and idle: rst low -> pixel_addr=0, pixel_valid=0, off_x=off_y=0. Release with in_valid=0 -> outputs stay 0.
- Basic map, offsets 0: h_cnt=10, v_cnt=4, in_valid=1 -> 2 cycles later pixel_addr=645, pixel_valid=1. Back-to-back inputs -> one result per cycle.
- X wrap: load_x=318 then frame_tick -> off_x=318. scroll_en=1, step_x=5, frame_tick -> off_x=3. Then h_cnt=638, v_cnt=0 -> pixel_addr=2.
- Shadow: load_x=400 mid-frame -> off_x unchanged until frame_tick, then off_x=80. load and frame_tick in the same cycle with scroll_en=1 -> off_x = loaded value, no step added.
- Range: h_cnt=640 (h_addr=320) or v_cnt=480 -> pixel_valid=0, pixel_addr=0. Assert rst with valid data in the pipe -> pixel_valid drops the same cycle.
- SCROLL_Y_EN: off_y=238, step_y=3, frame_tick -> off_y=1. Without the macro -> off_y stays 238.
